// File: rtl/ysyx_220053_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220053_ifu_prefetch
// Function : Instruction fetch unit with a decoupling prefetch queue.
//            Issues aligned fetch requests to the icache and splits each
//            FETCH_W-bit block into 32-bit instructions tagged with their PC.
//            It queues those instructions for decode. A backend redirect
//            flushes the queue and squashes any in-flight fetch.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_220053_ifu_prefetch #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned FETCH_W  = 64,
    parameter int unsigned DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [63:0]        redirect_pc,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [63:0]        inst_pc,
    input  logic               inst_ready,
    output logic               if_busy,
    output logic               req_valid,
    output logic [63:0]        req_addr,
    input  logic               req_ready,
    input  logic               resp_valid,
    input  logic [FETCH_W-1:0] resp_data
);

    localparam int unsigned c_NWORDS   = FETCH_W / 32;
    localparam int unsigned c_BLK_BITS = $clog2(FETCH_W / 8);
    localparam int unsigned c_OFF_W    = (c_NWORDS > 1) ? $clog2(c_NWORDS) : 1;
    localparam int unsigned c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_CNT_W    = c_PTR_W + 1;
    // Highest occupancy that still leaves room for a full fetch block.
    localparam logic [c_CNT_W-1:0] c_ISSUE_MAX = c_CNT_W'(DEPTH - c_NWORDS);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_DROP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [63:0]        r_fetch_pc;
    logic [31:0]        r_q_inst [DEPTH];
    logic [63:0]        r_q_pc   [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_OFF_W-1:0] w_off;
    logic [63:0]        w_blk_base;
    logic               w_has_space;
    logic               w_req_valid;
    logic               w_push;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_push_cnt;
    logic [c_PTR_W-1:0] w_slot [c_NWORDS];
    logic               w_unused;

    // Word offset of fetch_pc inside its block; zero when a block is one word.
    generate
        if (c_NWORDS > 1) begin : g_off
            assign w_off = r_fetch_pc[c_BLK_BITS-1:2];
        end else begin : g_off_single
            assign w_off = '0;
        end
    endgenerate

    assign w_blk_base  = {r_fetch_pc[63:c_BLK_BITS], {c_BLK_BITS{1'b0}}};
    assign w_has_space = (r_count <= c_ISSUE_MAX);
    assign w_push_cnt  = c_CNT_W'(c_NWORDS) - c_CNT_W'(w_off);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state. A response always retires the single outstanding request,
    // even when a redirect lands in the same cycle, so DROP can never wait
    // for a response that will not come.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_req_valid && req_ready) w_state_nxt = c_S_WAIT;
            c_S_WAIT: begin
                if (resp_valid) begin
                    w_state_nxt = c_S_IDLE;
                end else if (redirect_valid) begin
                    w_state_nxt = c_S_DROP;
                end
            end
            c_S_DROP: if (resp_valid) w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // FSM outputs: request issue, queue push and queue pop strobes.
    always_comb begin
        w_req_valid = (r_state == c_S_IDLE) && w_has_space && !redirect_valid && !rst;
        w_push      = (r_state == c_S_WAIT) && resp_valid && !redirect_valid;
        w_pop       = (r_count != '0) && inst_ready && !redirect_valid;
    end

    // Queue slot each fetched word lands in; words below the offset are skipped.
    always_comb begin
        for (int k = 0; k < int'(c_NWORDS); k++) begin
            w_slot[k] = r_wr_ptr + c_PTR_W'(k) - c_PTR_W'(w_off);
        end
    end

    // Queue storage; pointers guard validity so the data needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int k = 0; k < int'(c_NWORDS); k++) begin
                if (k >= int'(w_off)) begin
                    r_q_inst[w_slot[k]] <= resp_data[32*k +: 32];
                    r_q_pc[w_slot[k]]   <= w_blk_base + 64'(4 * k);
                end
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_push_cnt);
            r_count <= r_count + (w_push ? w_push_cnt : '0) - (w_pop ? c_CNT_W'(1) : '0);
        end
    end

    // Fetch PC: redirect target, or the next sequential block after a push.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[63:2], 2'b00};
        end else if (w_push) begin
            r_fetch_pc <= w_blk_base + 64'(FETCH_W / 8);
        end
    end

    assign inst_valid = (r_count != '0);
    assign if_busy    = (r_count == '0);
    assign inst       = inst_valid ? r_q_inst[r_rd_ptr] : 32'd0;
    assign inst_pc    = inst_valid ? r_q_pc[r_rd_ptr] : 64'd0;
    assign req_valid  = w_req_valid;
    assign req_addr   = w_blk_base;

    // Low PC bits are always zero and never consumed.
    assign w_unused = &{1'b0, redirect_pc[1:0], r_fetch_pc[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_ysyx_220053_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_220053_ifu_prefetch
// Function : Self-checking bench for the prefetch IFU. An icache responder
//            with random latency drives the DUT. A transaction-level model
//            (instruction queue, fetch PC, outstanding or stale request)
//            predicts every output cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_220053_ifu_prefetch;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int FETCH_W = 64;
    localparam int DEPTH   = 4;
    localparam int NW      = FETCH_W / 32;
    localparam int BLK     = FETCH_W / 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               redirect_valid;
    logic [63:0]        redirect_pc;
    logic               inst_valid;
    logic [31:0]        inst;
    logic [63:0]        inst_pc;
    logic               inst_ready;
    logic               if_busy;
    logic               req_valid;
    logic [63:0]        req_addr;
    logic               req_ready;
    logic               resp_valid;
    logic [FETCH_W-1:0] resp_data;

    ysyx_220053_ifu_prefetch #(
        .RESET_PC (RESET_PC),
        .FETCH_W  (FETCH_W),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .if_busy        (if_busy),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    // Reference model state
    ent_t        mq[$];
    logic [63:0] m_fetch_pc;
    bit          m_out;
    bit          m_stale;
    // Icache responder state
    bit          ic_pend;
    int          ic_at;
    int          g_lat;
    int          g_rr_pct;
    // Bookkeeping
    int          cyc;
    int          checks;
    int          failures;
    logic [63:0] hs_log[$];
    int          hs_cyc[$];
    logic [63:0] pop_log[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] get_hs(input int i);
        return (hs_log.size() > i) ? hs_log[i] : 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    function automatic int get_hs_cyc(input int i);
        return (hs_cyc.size() > i) ? hs_cyc[i] : -1;
    endfunction

    function automatic logic [63:0] get_pop(input int i);
        return (pop_log.size() > i) ? pop_log[i] : 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    task automatic clear_logs();
        hs_log.delete();
        hs_cyc.delete();
        pop_log.delete();
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model.
    task automatic cycle(input bit t_rst, input bit t_redir, input logic [63:0] t_rpc, input bit t_ready);
        bit                 rnow;
        bit                 exp_req;
        logic [FETCH_W-1:0] rd;
        logic [63:0]        base;
        ent_t               e;
        int                 off;
        rnow = ic_pend && (cyc == ic_at);
        for (int w = 0; w < NW; w++) rd[32*w +: 32] = $urandom;
        rst            = t_rst;
        redirect_valid = t_redir;
        redirect_pc    = t_rpc;
        inst_ready     = t_ready;
        req_ready      = !ic_pend && ($urandom_range(99) < g_rr_pct);
        resp_valid     = rnow;
        resp_data      = rd;
        @(negedge clk);
        exp_req = !t_rst && !m_out && ((DEPTH - mq.size()) >= NW) && !t_redir;
        check_eq("req_valid", req_valid, exp_req);
        if (!t_rst) begin
            check_eq("inst_valid", inst_valid, mq.size() != 0);
            check_eq("if_busy", if_busy, mq.size() == 0);
            if (mq.size() != 0) begin
                check_eq("inst", inst, mq[0].ins);
                check_eq("inst_pc", inst_pc, mq[0].pc);
            end
            if (exp_req) check_eq("req_addr", req_addr, m_fetch_pc & ~64'(BLK - 1));
        end
        if (req_valid && req_ready) begin
            hs_log.push_back(req_addr);
            hs_cyc.push_back(cyc);
        end
        if (inst_valid && t_ready && !t_redir && !t_rst) pop_log.push_back(inst_pc);
        // Model update
        if (t_rst) begin
            mq.delete();
            m_fetch_pc = RESET_PC;
            m_out      = 0;
            m_stale    = 0;
        end else if (t_redir) begin
            mq.delete();
            m_fetch_pc = {t_rpc[63:2], 2'b00};
            if (m_out) begin
                if (rnow) begin
                    m_out   = 0;
                    m_stale = 0;
                end else begin
                    m_stale = 1;
                end
            end
        end else begin
            if (mq.size() != 0 && t_ready) void'(mq.pop_front());
            if (m_out && rnow) begin
                if (!m_stale) begin
                    base = m_fetch_pc & ~64'(BLK - 1);
                    off  = int'((m_fetch_pc % 64'(BLK)) >> 2);
                    for (int k = off; k < NW; k++) begin
                        e.pc  = base + 64'(4 * k);
                        e.ins = rd[32*k +: 32];
                        mq.push_back(e);
                    end
                    m_fetch_pc = base + 64'(BLK);
                end
                m_out   = 0;
                m_stale = 0;
            end
            if (exp_req && req_ready) m_out = 1;
        end
        // Responder update
        if (rnow) ic_pend = 0;
        if (exp_req && req_ready) begin
            ic_pend = 1;
            ic_at   = cyc + ((g_lat != 0) ? g_lat : int'($urandom_range(4, 1)));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_inst_valid"}, inst_valid, 1'b0);
        check_eq({tag, "_if_busy"}, if_busy, 1'b1);
        check_eq({tag, "_inst"}, inst, 32'd0);
        check_eq({tag, "_inst_pc"}, inst_pc, 64'd0);
        check_eq({tag, "_req_valid"}, req_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          found;
        int          stale_at;
        int          r;
        logic [63:0] tgt;
        checks = 0; failures = 0; cyc = 0;
        ic_pend = 0; ic_at = 0; g_lat = 2; g_rr_pct = 100;
        m_fetch_pc = RESET_PC; m_out = 0; m_stale = 0;
        rst = 1; redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
        req_ready = 0; resp_valid = 0; resp_data = '0;
        @(posedge clk);
        #1;
        repeat (3) cycle(1, 0, 64'd0, 1);
        check_reset_outputs("reset");

        // Straight-line fetch, latency 2
        clear_logs();
        repeat (14) cycle(0, 0, 64'd0, 1);
        check_eq("line_req0", get_hs(0), 64'h8000_0000);
        check_eq("line_req1", get_hs(1), 64'h8000_0008);
        check_eq("line_req2", get_hs(2), 64'h8000_0010);
        check_eq("line_pc0", get_pop(0), 64'h8000_0000);
        check_eq("line_pc1", get_pop(1), 64'h8000_0004);
        check_eq("line_pc2", get_pop(2), 64'h8000_0008);
        check_eq("line_pc3", get_pop(3), 64'h8000_000C);

        // Unaligned start
        clear_logs();
        cycle(0, 1, 64'h8000_0104, 1);
        repeat (12) cycle(0, 0, 64'd0, 1);
        check_eq("unal_req0", get_hs(0), 64'h8000_0100);
        check_eq("unal_pc0", get_pop(0), 64'h8000_0104);
        check_eq("unal_req1", get_hs(1), 64'h8000_0108);
        check_eq("unal_pc1", get_pop(1), 64'h8000_0108);

        // Backpressure: fill the queue, then release
        clear_logs();
        cycle(0, 1, 64'h8000_1000, 0);
        repeat (20) cycle(0, 0, 64'd0, 0);
        check_eq("bp_full_req_valid", req_valid, 1'b0);
        check_eq("bp_full_inst_valid", inst_valid, 1'b1);
        check_eq("bp_full_head_pc", inst_pc, 64'h8000_1000);
        clear_logs();
        repeat (12) cycle(0, 0, 64'd0, 1);
        check_eq("bp_pc0", get_pop(0), 64'h8000_1000);
        check_eq("bp_pc1", get_pop(1), 64'h8000_1004);
        check_eq("bp_pc2", get_pop(2), 64'h8000_1008);
        check_eq("bp_pc3", get_pop(3), 64'h8000_100C);

        // Redirect while a fetch is outstanding
        g_lat = 3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (ic_pend && cyc != ic_at) found = 1;
            else cycle(0, 0, 64'd0, 1);
        end
        check_eq("wait_found", found, 1'b1);
        stale_at = ic_at;
        clear_logs();
        cycle(0, 1, 64'h8000_2000, 1);
        repeat (15) cycle(0, 0, 64'd0, 1);
        check_eq("wait_req0", get_hs(0), 64'h8000_2000);
        check_eq("wait_req_after_stale", get_hs_cyc(0) > stale_at, 1'b1);
        check_eq("wait_pc0", get_pop(0), 64'h8000_2000);

        // Redirect coinciding with pop and response
        g_lat = 2;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (ic_pend && cyc == ic_at && mq.size() != 0) begin
                found = 1;
                cycle(0, 1, 64'h8000_3000, 1);
            end else begin
                cycle(0, 0, 64'd0, 0);
            end
        end
        check_eq("coin_found", found, 1'b1);
        redirect_valid = 0;
        rst = 0;
        #1;
        check_eq("coin_inst_valid", inst_valid, 1'b0);
        check_eq("coin_if_busy", if_busy, 1'b1);
        check_eq("coin_req_valid", req_valid, 1'b1);
        check_eq("coin_req_addr", req_addr, 64'h8000_3000);
        clear_logs();
        repeat (10) cycle(0, 0, 64'd0, 1);
        check_eq("coin_req0", get_hs(0), 64'h8000_3000);

        // Reset during an outstanding fetch, then a late response
        g_lat = 4;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (ic_pend && cyc != ic_at) found = 1;
            else cycle(0, 0, 64'd0, 1);
        end
        check_eq("rstw_found", found, 1'b1);
        stale_at = ic_at;
        cycle(1, 0, 64'd0, 1);
        check_reset_outputs("rstw");
        clear_logs();
        repeat (15) cycle(0, 0, 64'd0, 1);
        check_eq("rstw_req0", get_hs(0), RESET_PC);
        check_eq("rstw_req_after_late", get_hs_cyc(0) > stale_at, 1'b1);
        check_eq("rstw_pc0", get_pop(0), RESET_PC);

        // Randomized traffic
        g_lat = 0;
        g_rr_pct = 75;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(999));
            case ($urandom_range(2))
                0:       tgt = {$urandom, $urandom};
                1:       tgt = 64'h8000_0000 + 64'($urandom_range(4095));
                default: tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
            endcase
            cycle(r < 5, (r >= 5) && (r < 35), tgt, $urandom_range(99) < 60);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
